// File: rtl/switch_out_buffer.sv
// rtl/switch_out_buffer.sv - credit-based switch output buffer with head bypass
module switch_out_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int DN_CREDITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  conf_en,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  up_credit,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  dn_credit,
  output logic                  err_overflow,
  output logic                  err_credit
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int KW = $clog2(DN_CREDITS) + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [KW-1:0] MAX_CREDIT = KW'(DN_CREDITS);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [KW-1:0]         r_credit;
  logic                  r_out_valid;
  logic                  r_up_credit;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_err_overflow;
  logic                  r_err_credit;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_send;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_overflow;
  logic                  w_dn_accept;
  logic                  w_dn_ignored;
  logic [DATA_WIDTH-1:0] w_head;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_CNT);
  // An arriving word into an empty FIFO is treated as the head so it leaves next cycle.
  assign w_send   = conf_en & (~w_empty | in_valid) & (r_credit != '0);
  assign w_bypass = w_empty & in_valid & w_send;
  assign w_head   = w_empty ? in_data : r_mem[r_rd_ptr];

  assign w_push       = in_valid & (~w_full | w_send) & ~w_bypass;
  assign w_pop        = w_send & ~w_empty;
  assign w_overflow   = in_valid & w_full & ~w_send;
  assign w_dn_ignored = dn_credit & (r_credit == MAX_CREDIT) & ~w_send;
  assign w_dn_accept  = dn_credit & ~w_dn_ignored;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_credit       <= MAX_CREDIT;
      r_out_valid    <= 1'b0;
      r_up_credit    <= 1'b0;
      r_out_data     <= '0;
      r_err_overflow <= 1'b0;
      r_err_credit   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      case ({w_send, w_dn_accept})
        2'b10:   r_credit <= r_credit - KW'(1);
        2'b01:   r_credit <= r_credit + KW'(1);
        default: r_credit <= r_credit;
      endcase
      r_out_valid <= w_send;
      r_up_credit <= w_send;
      if (w_send) r_out_data <= w_head;
      if (w_overflow)   r_err_overflow <= 1'b1;
      if (w_dn_ignored) r_err_credit   <= 1'b1;
    end
  end

  assign out_valid    = r_out_valid;
  assign up_credit    = r_up_credit;
  assign out_data     = r_out_data;
  assign err_overflow = r_err_overflow;
  assign err_credit   = r_err_credit;

endmodule

// File: tb/tb_switch_out_buffer.sv
// tb/tb_switch_out_buffer.sv - self-checking bench for switch_out_buffer
module tb_switch_out_buffer;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int DNC   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          conf_en = 1'b0;
  logic          in_valid = 1'b0;
  logic          dn_credit = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          up_credit;
  logic          out_valid;
  logic          err_overflow;
  logic          err_credit;
  logic [DW-1:0] out_data;

  switch_out_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DN_CREDITS(DNC)) dut (
    .clk(clk), .rst_n(rst_n), .conf_en(conf_en), .in_data(in_data),
    .in_valid(in_valid), .up_credit(up_credit), .out_data(out_data),
    .out_valid(out_valid), .dn_credit(dn_credit),
    .err_overflow(err_overflow), .err_credit(err_credit)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of buffered words plus a credit integer
  logic [DW-1:0] q[$];
  int            m_credit;
  bit            m_valid, m_ov, m_cr;
  logic [DW-1:0] m_data;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".out_valid"}, DW'(out_valid), DW'(m_valid));
    chk({tag, ".up_credit"}, DW'(up_credit), DW'(m_valid));
    chk({tag, ".out_data"}, out_data, m_data);
    chk({tag, ".err_overflow"}, DW'(err_overflow), DW'(m_ov));
    chk({tag, ".err_credit"}, DW'(err_credit), DW'(m_cr));
  endtask

  task automatic model_reset();
    q.delete();
    m_credit = DNC;
    m_valid = 0; m_ov = 0; m_cr = 0;
    m_data = '0;
  endtask

  task automatic step(input string tag, input bit c, input bit v, input logic [DW-1:0] d, input bit dn);
    bit send;
    conf_en = c; in_valid = v; in_data = d; dn_credit = dn;
    send = c && (q.size() > 0 || v) && m_credit > 0;
    if (v) begin
      if (q.size() < DEPTH || send) q.push_back(d);
      else m_ov = 1;
    end
    m_valid = send;
    if (send) begin
      m_data = q.pop_front();
      m_credit--;
    end
    if (dn) begin
      if (m_credit == DNC) m_cr = 1;
      else m_credit++;
    end
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_all({tag, ".asserted"});
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    async_reset("rst0");

    step("a5", 1, 1, 32'hA5, 0);
    chk("a5.const", out_data, 32'hA5);

    async_reset("rst1");
    step("p1", 1, 1, 32'h1, 0);
    step("p2", 1, 1, 32'h2, 0);
    chk("p2.const", out_data, 32'h2);
    step("p3", 1, 1, 32'h3, 0);
    step("p4", 1, 1, 32'h4, 0);
    chk("p4.noval", DW'(out_valid), 0);
    step("p5", 1, 1, 32'h5, 0);
    chk("p5.ovf", DW'(err_overflow), 1);

    step("dn1", 1, 0, 0, 1);
    step("s3", 1, 0, 0, 0);
    chk("s3.const", out_data, 32'h3);
    step("idle1", 1, 0, 0, 0);
    step("dn2", 1, 0, 0, 1);
    step("s4", 1, 0, 0, 0);
    chk("s4.const", out_data, 32'h4);

    step("dn3", 1, 0, 0, 1);
    step("snd_dn", 1, 1, 32'h66, 1);
    chk("snd_dn.nocr", DW'(err_credit), 0);
    step("dn4", 1, 0, 0, 1);
    step("dn_max", 1, 0, 0, 1);
    chk("dn_max.cr", DW'(err_credit), 1);

    step("c0", 0, 1, 32'h7, 0);
    step("c0b", 0, 0, 0, 0);
    chk("c0b.noval", DW'(out_valid), 0);
    step("c1", 1, 0, 0, 0);
    chk("c1.const", out_data, 32'h7);

    step("h1", 0, 1, 32'h11, 0);
    step("h2", 0, 1, 32'h22, 0);
    step("h3", 1, 0, 0, 0);
    async_reset("rst2");
    step("pr0", 1, 0, 0, 0);
    step("pr1", 1, 1, 32'hA, 0);
    step("pr2", 1, 1, 32'hB, 0);
    step("pr3", 1, 1, 32'hC, 0);
    chk("pr3.noval", DW'(out_valid), 0);

    async_reset("rst3");
    for (int i = 0; i < 400; i++) begin
      step($sformatf("rnd%0d", i), ($urandom % 4) != 0, $urandom % 2,
           $urandom, ($urandom % 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
